fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl.sv | 92 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: issues r_en and buffers returning words in a 2-entry skid buffer.
// Optional 16-bit pop counter output rd_count is built when FIFO_RD_CNT_EN is defined.
module fifo_rd_ctrl #(
  parameter int unsigned Data_Width = 8,
  parameter int unsigned Skid_Depth = 2
) (
  input  logic                  rclk,
  input  logic                  r_rst,
  input  logic                  empty,
  input  logic [Data_Width-1:0] rdata,
  output logic                  r_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [Data_Width-1:0] m_data
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0]           rd_count
`endif
);

  localparam int unsigned PtrW = $clog2(Skid_Depth);

  logic [Data_Width-1:0] r_mem [Skid_Depth];
  logic [PtrW-1:0]       r_head;
  logic [PtrW-1:0]       r_tail;
  logic [1:0]            r_occ;
  logic                  r_inflight;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_pop_eff;
  logic [1:0]            w_fill;

  always_comb begin
    m_valid   = (r_occ != 2'd0);
    m_data    = r_mem[r_head];
    w_pop     = m_valid & m_ready;
    // A flush cycle discards state, so neither the pop nor the returning word takes effect.
    w_pop_eff = w_pop & ~flush;
    w_push    = r_inflight & ~flush;
    w_fill    = r_occ + {1'b0, r_inflight};
    r_en      = ~empty & ~flush & ~r_rst & ((w_fill < 2'd2) | w_pop);
  end

  always_ff @(posedge rclk) begin
    if (r_rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      for (int i = 0; i < Skid_Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= r_en;
      if (w_push) begin
        r_mem[r_tail] <= rdata;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop_eff) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop_eff})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [15:0] r_count;

  // Survives flush; only reset clears it.
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      r_count <= 16'd0;
    end else if (w_pop_eff) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign rd_count = r_count;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomized and directed bench for fifo_rd_ctrl against a queue-based reference model.
module tb_fifo_rd_ctrl;

  logic       rclk;
  logic       r_rst;
  logic       empty;
  logic [7:0] rdata;
  logic       r_en;
  logic       flush;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] rd_count;
`endif

  fifo_rd_ctrl #(
    .Data_Width (8),
    .Skid_Depth (2)
  ) u_dut (
    .rclk     (rclk),
    .r_rst    (r_rst),
    .empty    (empty),
    .rdata    (rdata),
    .r_en     (r_en),
    .flush    (flush),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_count (rd_count)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: source FIFO contents, skid buffer contents, one in-flight word.
  logic [7:0] src_q[$];
  logic [7:0] skid_q[$];
  bit         m_infl;
  logic [7:0] m_infl_word;
  int         m_cnt;

  // Observation stats for directed scenarios.
  logic [7:0] acc_q[$];
  int cyc;
  int ren_cnt;
  int valid_cnt;
  int first_valid;
  int last_valid;
  int first_ren;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    acc_q.delete();
    ren_cnt     = 0;
    valid_cnt   = 0;
    first_valid = -1;
    last_valid  = -1;
    first_ren   = -1;
  endtask

  // One clock cycle: drive at negedge, compare before posedge, advance model at posedge.
  task automatic cycle(input bit rst_v, input bit flush_v, input bit ready_v, input bit stall_v);
    bit exp_valid;
    bit exp_ren;
    bit pop;
    r_rst   = rst_v;
    flush   = flush_v;
    m_ready = ready_v;
    empty   = stall_v || (src_q.size() == 0);
    rdata   = m_infl ? m_infl_word : 8'($urandom);
    #2;
    exp_valid = (skid_q.size() != 0);
    pop       = exp_valid && ready_v;
    exp_ren   = !empty && !flush_v && !rst_v && ((skid_q.size() + int'(m_infl) < 2) || pop);
    check_val("m_valid", {31'd0, m_valid}, {31'd0, exp_valid});
    check_val("r_en", {31'd0, r_en}, {31'd0, exp_ren});
    if (exp_valid) check_val("m_data", {24'd0, m_data}, {24'd0, skid_q[0]});
`ifdef FIFO_RD_CNT_EN
    check_val("rd_count", {16'd0, rd_count}, m_cnt);
`endif
    if (r_en) begin
      ren_cnt++;
      if (first_ren < 0) first_ren = cyc;
    end
    if (m_valid) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
      if (m_ready && !flush_v && !rst_v) acc_q.push_back(m_data);
    end
    @(posedge rclk);
    if (rst_v) begin
      skid_q.delete();
      m_infl = 1'b0;
      m_cnt  = 0;
    end else if (flush_v) begin
      skid_q.delete();
      m_infl = 1'b0;
    end else begin
      if (pop) begin
        void'(skid_q.pop_front());
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (m_infl) skid_q.push_back(m_infl_word);
      m_infl = exp_ren;
      if (exp_ren) m_infl_word = src_q.pop_front();
    end
    cyc++;
    @(negedge rclk);
  endtask

  initial begin
    logic [7:0] seq;
    bit         reached;
    m_infl = 1'b0;
    m_infl_word = 8'd0;
    m_cnt = 0;
    cyc = 0;
    seq = 8'd0;
    clear_stats();
    r_rst = 1'b1;
    flush = 1'b0;
    m_ready = 1'b0;
    empty = 1'b1;
    rdata = 8'd0;
    @(posedge rclk);
    @(negedge rclk);

    // Reset held with words available: r_en must stay low.
    src_q = '{8'h01, 8'h02};
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_val("rst_m_data", {24'd0, m_data}, 32'h0);
    check_val("rst_m_valid", {31'd0, m_valid}, 32'h0);
    check_val("rst_ren_cnt", ren_cnt, 0);
    src_q.delete();

    // Empty guard.
    clear_stats();
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'($urandom), 1'b0);
    check_val("guard_ren", ren_cnt, 0);
    check_val("guard_valid", valid_cnt, 0);

    // Burst of three words with m_ready held high.
    clear_stats();
    src_q = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("burst_ren", ren_cnt, 3);
    check_val("burst_valid", valid_cnt, 3);
    check_val("burst_contig", last_valid - first_valid, 2);
    check_val("burst_lat", first_valid - first_ren, 2);
    check_val("burst_n", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check_val("burst_w0", {24'd0, acc_q[0]}, 32'h11);
      check_val("burst_w1", {24'd0, acc_q[1]}, 32'h22);
      check_val("burst_w2", {24'd0, acc_q[2]}, 32'h33);
    end

    // Backpressure: five words, downstream stalled, then released.
    clear_stats();
    src_q = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("bp_ren", ren_cnt, 2);
    check_val("bp_hold", {24'd0, m_data}, 32'h40);
    check_val("bp_valid", {31'd0, m_valid}, 32'h1);
    clear_stats();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("bp_n", acc_q.size(), 5);
    check_val("bp_contig", last_valid - first_valid, 4);
    for (int i = 0; i < acc_q.size() && i < 5; i++)
      check_val("bp_word", {24'd0, acc_q[i]}, 32'h40 + i);

    // Flush with one buffered word and one in flight.
    clear_stats();
    src_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      if (skid_q.size() == 1 && m_infl) reached = 1'b1;
      else cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_val("flush_setup", {31'd0, reached}, 32'h1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    clear_stats();
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("flush_n", acc_q.size(), 6);
    if (acc_q.size() > 0) check_val("flush_first", {24'd0, acc_q[0]}, 32'h52);

    // Reset mid-stream, then a fresh word 0xA5.
    src_q = '{8'h60, 8'h61, 8'h62};
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    src_q.delete();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    clear_stats();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("rst_ms_valid", valid_cnt, 0);
    src_q.push_back(8'hA5);
    clear_stats();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("a5_lat", first_valid - first_ren, 2);
    check_val("a5_n", acc_q.size(), 1);
    if (acc_q.size() > 0) check_val("a5_word", {24'd0, acc_q[0]}, 32'hA5);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 4000; i++) begin
      if (src_q.size() < 4 && $urandom_range(0, 99) < 60) begin
        src_q.push_back(seq);
        seq = seq + 8'd1;
      end
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
